// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: buffers one A and one B matrix and streams them, optionally
// diagonal-skewed, into a SIZE x SIZE systolic array with clear/feed/drain/done sequencing.
module systolic_operand_feeder #(
    parameter int SIZE = 3,
    parameter int DATA_WIDTH = 8,
    parameter int SKEW_EN = 0,
    parameter int DRAIN_CYCLES = 2,
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic                               wr_sel,
    input  logic [IW-1:0]                      wr_row,
    input  logic [IW-1:0]                      wr_col,
    input  logic signed [DATA_WIDTH-1:0]       wr_data,
    input  logic                               start,
    output logic                               busy,
    output logic                               clear_out,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]    A_out,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]    B_out,
    output logic                               feed_valid,
    output logic                               done
);
    localparam int NSTEP = (SKEW_EN != 0) ? 3 * SIZE - 2 : SIZE;
    localparam int CW = $clog2(NSTEP + DRAIN_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                          state;
    logic [CW-1:0]                   step;
    logic [DATA_WIDTH-1:0]           a_buf [SIZE][SIZE];
    logic [DATA_WIDTH-1:0]           b_buf [SIZE][SIZE];
    logic [SIZE-1:0][DATA_WIDTH-1:0] nxt_a, nxt_b;

    // Operands for the step about to be presented; CLEAR preloads step 0.
    always_comb begin
        int t, d;
        nxt_a = '0;
        nxt_b = '0;
        t = (state == CLEAR) ? 0 : int'(step);
        for (int i = 0; i < SIZE; i++) begin
            d = (SKEW_EN != 0) ? t - i : t;
            if (d >= 0 && d < SIZE) begin
                nxt_a[i] = a_buf[i][d[IW-1:0]];
                nxt_b[i] = b_buf[d[IW-1:0]][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_out  <= 1'b0;
            feed_valid <= 1'b0;
            done       <= 1'b0;
            A_out      <= '0;
            B_out      <= '0;
            step       <= '0;
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en && int'(wr_row) < SIZE && int'(wr_col) < SIZE) begin
                        if (wr_sel) b_buf[wr_row][wr_col] <= wr_data;
                        else        a_buf[wr_row][wr_col] <= wr_data;
                    end
                    if (start) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        clear_out <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= FEED;
                    clear_out  <= 1'b0;
                    feed_valid <= 1'b1;
                    A_out      <= nxt_a;
                    B_out      <= nxt_b;
                    step       <= CW'(1);
                end
                FEED: begin
                    if (step == CW'(NSTEP)) begin
                        state      <= (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                        done       <= (DRAIN_CYCLES == 0);
                        feed_valid <= 1'b0;
                        A_out      <= '0;
                        B_out      <= '0;
                        step       <= CW'(1);
                    end else begin
                        A_out <= nxt_a;
                        B_out <= nxt_b;
                        step  <= step + CW'(1);
                    end
                end
                DRAIN: begin
                    if (step == CW'(DRAIN_CYCLES)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb_systolic_operand_feeder: directed table-driven checks of lockstep, skewed and zero-drain
// feeders sharing one write bus, plus signed, busy-lockout and mid-sequence reset sequences.
module tb_systolic_operand_feeder;
    typedef struct packed {
        logic clr, fv, bsy, dn;
        logic [2:0][7:0] a, b;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, wr_sel = 1'b0;
    logic [1:0] wr_row = '0, wr_col = '0;
    logic signed [7:0] wr_data = '0;
    logic [2:0] start = '0;
    logic [2:0] busy, clr, fv, dn;
    logic [2:0][7:0] a_w [3];
    logic [2:0][7:0] b_w [3];
    int checks = 0, errors = 0;
    vec_t tbl [16];

    always #5 clk = ~clk;

    systolic_operand_feeder #(.SIZE(3), .DATA_WIDTH(8), .SKEW_EN(0), .DRAIN_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start[0]), .busy(busy[0]), .clear_out(clr[0]), .A_out(a_w[0]),
        .B_out(b_w[0]), .feed_valid(fv[0]), .done(dn[0]));
    systolic_operand_feeder #(.SIZE(3), .DATA_WIDTH(8), .SKEW_EN(1), .DRAIN_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start[1]), .busy(busy[1]), .clear_out(clr[1]), .A_out(a_w[1]),
        .B_out(b_w[1]), .feed_valid(fv[1]), .done(dn[1]));
    systolic_operand_feeder #(.SIZE(3), .DATA_WIDTH(8), .SKEW_EN(0), .DRAIN_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start[2]), .busy(busy[2]), .clear_out(clr[2]), .A_out(a_w[2]),
        .B_out(b_w[2]), .feed_valid(fv[2]), .done(dn[2]));

    function automatic vec_t mk(input logic c, f, bs, d, input int a0, a1, a2, b0, b1, b2);
        vec_t v;
        v.clr = c;
        v.fv  = f;
        v.bsy = bs;
        v.dn  = d;
        v.a   = {8'(a2), 8'(a1), 8'(a0)};
        v.b   = {8'(b2), 8'(b1), 8'(b0)};
        return v;
    endfunction

    function automatic vec_t obs(input int d);
        vec_t v;
        v.clr = clr[d];
        v.fv  = fv[d];
        v.bsy = busy[d];
        v.dn  = dn[d];
        v.a   = a_w[d];
        v.b   = b_w[d];
        return v;
    endfunction

    task automatic chk(input string nm, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got clr=%b fv=%b busy=%b done=%b A=%h B=%h, want clr=%b fv=%b busy=%b done=%b A=%h B=%h",
                     nm, act.clr, act.fv, act.bsy, act.dn, act.a, act.b,
                     exp.clr, exp.fv, exp.bsy, exp.dn, exp.a, exp.b);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic s, input int r, input int c, input int v);
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 8'(v);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Lockstep, DRAIN_CYCLES=2 frame: clear, three feed steps, two drain, done, idle.
    task automatic frame3(input vec_t f1, input vec_t f2, input vec_t f3);
        tbl[0] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = f1;
        tbl[2] = f2;
        tbl[3] = f3;
        tbl[4] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[6] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_table(input int d, input int n, input string nm);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s cyc%0d", nm, k + 1), obs(d), tbl[k]);
            @(negedge clk);
        end
    endtask

    initial begin
        int ndone;
        vec_t z, sv;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("reset dut%0d", d), obs(d), z);
        rst = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                wr(0, r, c, 3 * r + c + 1);
                wr(1, r, c, (r == c) ? 1 : 0);
            end

        frame3(mk(0, 1, 1, 0, 1, 4, 7, 1, 0, 0),
               mk(0, 1, 1, 0, 2, 5, 8, 0, 1, 0),
               mk(0, 1, 1, 0, 3, 6, 9, 0, 0, 1));
        run_table(0, 8, "noskew");

        tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 2, 4, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 3, 5, 7, 0, 1, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 6, 8, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 0, 9, 0, 0, 1);
        tbl[6]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = z;
        run_table(1, 12, "skew");

        tbl[0] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 1, 0, 1, 4, 7, 1, 0, 0);
        tbl[2] = mk(0, 1, 1, 0, 2, 5, 8, 0, 1, 0);
        tbl[3] = mk(0, 1, 1, 0, 3, 6, 9, 0, 0, 1);
        tbl[4] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[5] = z;
        tbl[6] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        start[2] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("nodrain held cyc%0d", k + 1), obs(2), tbl[k]);
            @(negedge clk);
        end
        start[2] = 1'b0;
        repeat (8) @(negedge clk);
        chk("nodrain settle idle", obs(2), z);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                wr(0, r, c, -128);
                wr(1, r, c, 127);
            end
        wr(0, 3, 0, 55);
        wr(1, 0, 3, 55);
        sv = mk(0, 1, 1, 0, -128, -128, -128, 127, 127, 127);
        frame3(sv, sv, sv);
        run_table(0, 8, "signed");

        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            start[0] = (k == 2 || k == 5) ? 1'b1 : (k == 0);
            start[0] = (k == 2 || k == 5);
            wr_en    = (k == 3);
            wr_sel   = 1'b0;
            wr_row   = 2'd0;
            wr_col   = 2'd0;
            wr_data  = 8'sd99;
            ndone += int'(dn[0]);
            @(negedge clk);
        end
        start[0] = 1'b0;
        wr_en    = 1'b0;
        chk_int("busy lockout done count", ndone, 1);
        chk("busy lockout idle", obs(0), z);
        run_table(0, 8, "signed rerun");

        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("mid-feed reset", obs(0), z);
        @(negedge clk);
        rst = 1'b1;
        frame3(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        run_table(0, 8, "post-reset zeros");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Upstream stage of the SIZE×SIZE systolic array. Buffers one A matrix and one B matrix written through a simple write port.
- On start, drives the array's clear, A_in[] and B_in[] inputs: row i of A on lane A_out[i], column j of B on lane B_out[j], one k-index per cycle.
- Supports unskewed feeding for the non-pipelined array and diagonal-skewed feeding for the pipelined array. Reports busy/done so a controller can sample C_out.

Parameters:
- SIZE, 3, matrix dimension and number of lanes.
- DATA_WIDTH, 8, signed operand width.
- SKEW_EN, 0, 0 = lanes fed in lockstep; 1 = lane i delayed by i cycles.
- DRAIN_CYCLES, 2, zero-feed cycles after the last operand, before done.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  operand buffer write strobe.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_row  in  $clog2(SIZE)  row index.
- wr_col  in  $clog2(SIZE)  column index.
- wr_data  in  DATA_WIDTH signed  element value.
- start  in  1  begin a feed sequence.
- busy  out  1  sequence in progress; high from the cycle after start is accepted through the done cycle.
- clear_out  out  1  to array clear.
- A_out  out  [SIZE] × DATA_WIDTH signed  to array A_in.
- B_out  out  [SIZE] × DATA_WIDTH signed  to array B_in.
- feed_valid  out  1  high during FEED cycles.
- done  out  1  one-cycle pulse when the array result is final.

Behaviour:
- All outputs registered. Reset (rst=0, asynchronous) does the following:
  - state=IDLE;
  - busy, clear_out, feed_valid, done = 0;
  - all A_out/B_out lanes = 0;
  - both buffers zeroed;
  - step counter = 0.
- Writes: on an edge with wr_en=1 in IDLE, buf[wr_sel][wr_row][wr_col] <= wr_data.
  - Writes are ignored while busy.
  - Writes with an index ≥ SIZE are ignored.
  - A write and a start on the same IDLE edge: the write lands first and is used by the sequence.
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
  - IDLE: outputs zero. Edge with start=1 → CLEAR; busy<=1, clear_out<=1.
  - CLEAR: exactly one cycle, lanes zero. → FEED, step=0.
  - FEED: NSTEP = SIZE if SKEW_EN=0, else 3*SIZE-2. feed_valid=1. Each cycle presents step t:
    - SKEW_EN=0: A_out[i] = A[i][t], B_out[j] = B[t][j].
    - SKEW_EN=1: A_out[i] = A[i][t-i] when 0 ≤ t-i < SIZE, else 0; B_out[j] = B[t-j][j] when 0 ≤ t-j < SIZE, else 0.
    - After step NSTEP-1 → DRAIN.
  - DRAIN: DRAIN_CYCLES cycles, lanes zero, feed_valid=0. DRAIN_CYCLES=0 skips directly to DONE.
  - DONE: one cycle, done=1, busy=1, lanes zero. → IDLE, busy<=0.
- Latency: start sampled at edge E.
  - clear_out high in cycle E+1.
  - First operands in cycle E+2.
  - done in cycle E+2+NSTEP+DRAIN_CYCLES.
- start while busy is ignored; no queuing.
- start held high across done re-triggers on the IDLE cycle that follows.
- Buffers persist across sequences; the same operands may be re-run with start only.
- Reset mid-sequence aborts immediately: lanes drop to 0 and no done is produced.
- Lane values are copied from the buffers unchanged; no arithmetic. Signedness is preserved.

Test Plan:
- Reset: rst=0 mid-FEED → next sample: busy=0, done=0, all lanes 0. Buffer readback via a subsequent start feeds zeros.
- SKEW_EN=0, A=[[1,2,3],[4,5,6],[7,8,9]], B=I → after clear, A_out=(1,4,7),(2,5,8),(3,6,9) and B_out=(1,0,0),(0,1,0),(0,0,1). done at E+7. Attached array C_out equals A.
- SKEW_EN=1, same A → A_out steps (1,0,0),(2,4,0),(3,5,7),(0,6,8),(0,0,9). feed_valid high for exactly 7 cycles. done at E+11.
- Signed values: A=all -128, B=all 127 → lanes carry 8'h80/8'h7F. Array C_out = -48768 on each element.
- start pulses and wr_en during busy → no retrigger, buffers unchanged, only one done pulse.
- DRAIN_CYCLES=0 with start held high → done followed by IDLE, then a second sequence begins with clear_out one cycle later.
